// File: rtl/fft_r4_combine_ctrl.sv
// fft_r4_combine_ctrl: frame scheduler for the radix-4 combine stage (sub-FFT bank -> twiddle mult -> butterfly)
//   clk, reset     : clock, synchronous active-high reset
//   sfft_ready[3:0]: per sub-FFT result-buffer-full level
//   sfft_release   : per sub-FFT one-cycle buffer release pulse
//   rd_en/rd_addr  : broadcast read strobe and quarter index
//   phi            : twiddle phase, rd_addr zero-extended
//   mult_en        : multiplier enable covering rd_en and its two-cycle tail
//   combine_valid  : butterfly output sample valid
//   frame_done     : one-cycle end-of-frame pulse (downstream clear)
//   busy           : frame in progress
//   err_timeout    : one-cycle assembly-timeout or drain-overrun pulse
//   frame_count    : completed error-free frames, only with FFT_CTRL_FRAME_CNT_EN defined
module fft_r4_combine_ctrl #(
  parameter int SIZE_BUFFER = 6,
  parameter int DRAIN_MAX = 32,
  parameter int TIMEOUT = 1023,
  parameter int TW = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             sfft_ready,
  output logic [3:0]             sfft_release,
  output logic                   rd_en,
  output logic [SIZE_BUFFER-3:0] rd_addr,
  output logic [15:0]            phi,
  output logic                   mult_en,
  input  logic                   combine_valid,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   err_timeout
`ifdef FFT_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]            frame_count
`endif
);
  localparam int AW = SIZE_BUFFER - 2;
  localparam logic [AW:0] NQ = {1'b1, {AW{1'b0}}};
  typedef enum logic [2:0] {IDLE, ARM, STREAM, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [TW-1:0] wait_cnt, wait_nxt, wd_cnt, wd_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic [AW:0] smp_cnt, smp_nxt;
  logic [1:0] rd_dly;
  logic partial;
  assign partial = sfft_ready != 4'h0 && sfft_ready != 4'hF;
  assign rd_en = state == STREAM;
  assign rd_addr = rd_en ? addr : '0;
  assign phi = 16'(rd_addr);
  assign mult_en = rd_en | (|rd_dly);
  assign busy = state != IDLE;
  assign frame_done = state == DONE;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      wd_cnt <= '0;
      addr <= '0;
      smp_cnt <= '0;
      rd_dly <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      wd_cnt <= wd_nxt;
      addr <= addr_nxt;
      smp_cnt <= smp_nxt;
      rd_dly <= {rd_dly[0], rd_en};
    end
  // wait counter defaults to clear, so it only survives while a partial set is held in IDLE
  always_comb begin
    state_nxt = state;
    wait_nxt = '0;
    wd_nxt = wd_cnt;
    addr_nxt = addr;
    err_timeout = 1'b0;
    sfft_release = 4'h0;
    smp_nxt = (state inside {STREAM, DRAIN}) && combine_valid && smp_cnt != NQ ? smp_cnt + 1'b1 : smp_cnt;
    case (state)
      IDLE: begin
        if (sfft_ready == 4'hF) state_nxt = ARM;
        else if (partial && wait_cnt == TW'(TIMEOUT)) begin
          err_timeout = 1'b1;
          sfft_release = sfft_ready;
        end else if (partial) wait_nxt = wait_cnt + 1'b1;
      end
      ARM: begin
        smp_nxt = '0;
        wd_nxt = '0;
        addr_nxt = '0;
        state_nxt = STREAM;
      end
      STREAM: begin
        addr_nxt = addr + 1'b1;
        state_nxt = addr == '1 ? DRAIN : STREAM;
      end
      DRAIN: begin
        wd_nxt = wd_cnt + 1'b1;
        // a sample completing this cycle beats the watchdog
        if (smp_nxt == NQ) state_nxt = DONE;
        else if (wd_cnt == TW'(DRAIN_MAX)) begin
          err_timeout = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        sfft_release = 4'hF;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`ifdef FFT_CTRL_FRAME_CNT_EN
  logic drain_err;
  // frames that ended on a drain overrun are not counted
  always_ff @(posedge clk)
    if (reset) begin
      frame_count <= '0;
      drain_err <= 1'b0;
    end else begin
      drain_err <= frame_done ? 1'b0 : drain_err | (err_timeout && state == DRAIN);
      if (frame_done && !drain_err) frame_count <= frame_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fft_r4_combine_ctrl.sv
// tb_fft_r4_combine_ctrl: directed and randomized frame checks against a frame-level schedule model
module tb_fft_r4_combine_ctrl;
  localparam int NQ = 16;
  localparam int DMAX = 32;
  localparam int TMO = 100;
  logic clk, reset, rd_en, mult_en, combine_valid, frame_done, busy, err_timeout;
  logic [3:0] sfft_ready, sfft_release, rd_addr;
  logic [15:0] phi;
  logic [28:0] obs;
  int checks = 0, errors = 0, cyc = 0;
`ifdef FFT_CTRL_FRAME_CNT_EN
  logic [15:0] frame_count;
  logic [15:0] exp_fc = '0;
`endif
  fft_r4_combine_ctrl #(.SIZE_BUFFER(6), .DRAIN_MAX(DMAX), .TIMEOUT(TMO), .TW(10)) dut (
    .clk(clk),
    .reset(reset),
    .sfft_ready(sfft_ready),
    .sfft_release(sfft_release),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .phi(phi),
    .mult_en(mult_en),
    .combine_valid(combine_valid),
    .frame_done(frame_done),
    .busy(busy),
    .err_timeout(err_timeout)
`ifdef FFT_CTRL_FRAME_CNT_EN
    ,
    .frame_count(frame_count)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign obs = {rd_en, rd_addr, phi, busy, frame_done, sfft_release, err_timeout, mult_en};
  function automatic logic [28:0] pk(input bit rd, input int a, input bit bz, input bit dn,
                                     input logic [3:0] rel, input bit er, input bit me);
    logic [3:0] ad;
    ad = 4'(a);
    return {rd, ad, 12'h0, ad, bz, dn, rel, er, me};
  endfunction
  task automatic step(input string tag, input logic [28:0] exp);
    @(negedge clk);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @%0d: got {rd,addr,phi,busy,done,rel,err,mult}=%h expected %h", tag, cyc, obs, exp);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  // idle cycles with a fixed ready pattern; fe is the cycle of the first expected timeout
  task automatic idle(input string tag, input int n, input logic [3:0] rdy, input int fe);
    bit er;
    for (int c = 0; c < n; c++) begin
      sfft_ready = rdy;
      combine_valid = 1'($urandom_range(1));
      er = fe >= 0 && c >= fe && (c - fe) % (TMO + 1) == 0;
      step(tag, pk(0, 0, 0, 0, er ? rdy : 4'h0, er, 0));
    end
    combine_valid = 1'b0;
  endtask
  // one frame from the all-ready cycle; schedule derived from the valid pattern
  task automatic frame(input string tag, input int lat, input int drop, input bit hold,
                       input bit noise, input int abort);
    bit vld [64];
    int e, v, n, dn, er, last;
    bit rd;
    e = 2 + NQ;
    foreach (vld[i]) vld[i] = 1'b0;
    for (int i = 0; i < NQ; i++) vld[2+i+lat] = $urandom_range(99) >= drop;
    if (drop > 0 && drop < 100)
      for (int i = NQ; i < NQ + 10; i++) vld[2+i+lat] = $urandom_range(1) == 1;
    if (noise) begin
      vld[0] = 1'b1;
      vld[1] = 1'b1;
    end
    n = 0;
    v = -1;
    for (int i = 2; i < 64; i++)
      if (vld[i] && v < 0) begin
        n++;
        if (n == NQ) v = i;
      end
    er = (v >= 0 && v <= e + DMAX) ? -1 : e + DMAX;
    dn = er >= 0 ? er + 1 : (v > e ? v : e) + 1;
    last = abort >= 0 ? abort : dn;
    for (int c = 0; c <= last; c++) begin
      sfft_ready = c == 0 ? 4'hF : 4'($urandom);
      combine_valid = vld[c];
      if (c == abort) reset = 1'b1;
      rd = c >= 2 && c < e;
      step(tag, pk(rd, rd ? c - 2 : 0, c >= 1, c == dn, c == dn ? 4'hF : 4'h0, c == er,
                   c >= 2 && c <= e + 1));
    end
    reset = 1'b0;
    combine_valid = 1'b0;
    sfft_ready = hold ? 4'hF : 4'h0;
`ifdef FFT_CTRL_FRAME_CNT_EN
    if (abort < 0 && er < 0) exp_fc++;
    checks++;
    assert (frame_count === exp_fc) else begin
      errors++;
      $error("FAIL %s frame_count @%0d: got %0d expected %0d", tag, cyc, frame_count, exp_fc);
    end
`endif
  endtask
  initial begin
    reset = 1'b1;
    sfft_ready = 4'h0;
    combine_valid = 1'b0;
    @(posedge clk);
    #1;
    step("reset", '0);
    step("reset", '0);
    reset = 1'b0;
    idle("pre", 10, 4'h0, -1);
    frame("basic", 5, 0, 0, 0, -1);
    idle("gap", 5, 4'h0, -1);
    idle("partial", 35, 4'b0111, -1);
    frame("late_bit3", 3, 0, 0, 0, -1);
    idle("gap", 2, 4'h0, -1);
    idle("assy_timeout", 150, 4'b0011, TMO);
    idle("gap", 2, 4'h0, -1);
    idle("clr_a", 60, 4'b0011, -1);
    idle("clr_zero", 1, 4'h0, -1);
    idle("clr_b", 60, 4'b1100, -1);
    idle("gap", 1, 4'h0, -1);
    frame("drain_ovr", 4, 100, 0, 1, -1);
    idle("gap", 2, 4'h0, -1);
    frame("abort", 2, 0, 0, 0, 9);
    idle("post_reset", 2, 4'h0, -1);
    frame("restart", 2, 0, 0, 0, -1);
    frame("b2b_1", 4, 0, 1, 1, -1);
    frame("b2b_2", 4, 0, 0, 1, -1);
    idle("gap", 1, 4'h0, -1);
    for (int k = 0; k < 8; k++) begin
      int d;
      bit h;
      d = k % 4 == 3 ? 60 : (k % 4 == 2 ? 15 : 0);
      h = 1'($urandom_range(1));
      frame("rand", $urandom_range(1, 8), d, h, 1, -1);
      if (!h) idle("rand_gap", $urandom_range(1, 3), 4'h0, -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
